// File: rtl/env_vca_pkg.sv
// Shared types and constants for the env_vca envelope generator / VCA.
// Holds the envelope state encoding and the oscillator-to-sample mapping.
package env_vca_pkg;

    localparam int unsigned ENV_W = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_t;

    localparam logic [ENV_W-1:0] ENV_MAX = 8'd255;
    localparam logic [ENV_W-1:0] PWM_MID = 8'd128;

    // Bipolar square wave around midscale, amplitude set by the envelope level.
    function automatic logic [ENV_W-1:0] amp_sample(input logic osc,
                                                    input logic [ENV_W-1:0] level);
        logic [ENV_W-1:0] half;
        half = {1'b0, level[ENV_W-1:1]};
        return osc ? (PWM_MID + half) : ((PWM_MID - 8'd1) - half);
    endfunction

endpackage

// File: rtl/env_vca_pwm_dac.sv
// 8-bit PWM DAC: free-running counter, sample latched at the frame boundary,
// registered compare output.
module pwm_dac
    import env_vca_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [ENV_W-1:0] sample,
    output logic             pwm_out
);

    logic [ENV_W-1:0] count;
    logic [ENV_W-1:0] latched;

    // Sample only changes at count 255 so each frame uses one stable value.
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            latched <= PWM_MID;
            pwm_out <= 1'b0;
        end else begin
            count   <= count + 8'd1;
            if (count == 8'hFF) begin
                latched <= sample;
            end
            pwm_out <= (count < latched);
        end
    end

endmodule

// File: rtl/env_vca.sv
// ADSR envelope generator + VCA driving a PWM DAC from a 1-bit oscillator.
// Define ENV_VCA_SYNC_EN to add a two-flop synchronizer on the gate input.
module env_vca
    import env_vca_pkg::*;
#(
    parameter int unsigned PRESCALE_BITS = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gate,
    input  logic             osc_in,
    input  logic [ENV_W-1:0] attack_rate,
    input  logic [ENV_W-1:0] decay_rate,
    input  logic [ENV_W-1:0] sustain_level,
    input  logic [ENV_W-1:0] release_rate,
    output logic [ENV_W-1:0] env_level,
    output logic             active,
    output logic             pwm_out
);

    env_state_t              state;
    env_state_t              state_next;
    logic [ENV_W-1:0]        level_next;
    logic                    active_next;
    logic [ENV_W-1:0]        sample_c;

    logic [PRESCALE_BITS-1:0] prescaler;
    logic                     tick_c;

    logic gate_q;
    logic gate_prev;
    logic gate_rise_c;
    logic gate_fall_c;

    // Envelope tick every 2^PRESCALE_BITS clocks; never restarted by the gate.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PRESCALE_BITS'(1);
        end
    end

    assign tick_c = &prescaler;

`ifdef ENV_VCA_SYNC_EN
    logic gate_s1;
    logic gate_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            gate_s1   <= 1'b0;
            gate_s2   <= 1'b0;
            gate_q    <= 1'b0;
            gate_prev <= 1'b0;
        end else begin
            gate_s1   <= gate;
            gate_s2   <= gate_s1;
            gate_q    <= gate_s2;
            gate_prev <= gate_q;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            gate_q    <= 1'b0;
            gate_prev <= 1'b0;
        end else begin
            gate_q    <= gate;
            gate_prev <= gate_q;
        end
    end
`endif

    assign gate_rise_c = gate_q & ~gate_prev;
    assign gate_fall_c = ~gate_q & gate_prev;

    // Steps are rate+1 (1..256); 9 bits hold every sum below without wrap.
    logic [8:0] attack_step;
    logic [8:0] decay_step;
    logic [8:0] release_step;
    logic [8:0] attack_sum;
    logic [8:0] decay_floor;

    assign attack_step  = {1'b0, attack_rate}  + 9'd1;
    assign decay_step   = {1'b0, decay_rate}   + 9'd1;
    assign release_step = {1'b0, release_rate} + 9'd1;
    assign attack_sum   = {1'b0, env_level} + attack_step;
    assign decay_floor  = decay_step + {1'b0, sustain_level};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            env_level <= '0;
            active    <= 1'b0;
        end else begin
            state     <= state_next;
            env_level <= level_next;
            active    <= active_next;
        end
    end

    // Next state and level; a gate edge takes priority over a tick.
    always_comb begin
        state_next = state;
        level_next = env_level;
        if (gate_rise_c) begin
            state_next = ATTACK;
        end else if (gate_fall_c &&
                     (state == ATTACK || state == DECAY || state == SUSTAIN)) begin
            state_next = RELEASE;
        end else if (tick_c) begin
            case (state)
                IDLE: begin
                    state_next = IDLE;
                end
                ATTACK: begin
                    if (attack_sum >= 9'd255) begin
                        level_next = ENV_MAX;
                        state_next = DECAY;
                    end else begin
                        level_next = attack_sum[ENV_W-1:0];
                    end
                end
                DECAY: begin
                    // level - step <= sustain, rearranged to stay unsigned.
                    if ({1'b0, env_level} <= decay_floor) begin
                        level_next = sustain_level;
                        state_next = SUSTAIN;
                    end else begin
                        level_next = env_level - decay_step[ENV_W-1:0];
                    end
                end
                SUSTAIN: begin
                    level_next = sustain_level;
                end
                RELEASE: begin
                    if ({1'b0, env_level} <= release_step) begin
                        level_next = '0;
                        state_next = IDLE;
                    end else begin
                        level_next = env_level - release_step[ENV_W-1:0];
                    end
                end
                default: begin
                    level_next = '0;
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Outputs: active follows the registered state; sample feeds the DAC.
    always_comb begin
        active_next = (state != IDLE);
        sample_c    = amp_sample(osc_in, env_level);
    end

    pwm_dac u_pwm_dac (
        .clk     (clk),
        .rst     (rst),
        .sample  (sample_c),
        .pwm_out (pwm_out)
    );

endmodule
